// File: rtl/alu_pkg.sv
// Shared types and constants for the multicycle ALU (alu_mc) and its iterative mul/div unit.
package alu_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_BUS_WIDTH    = 8;
  localparam int DEF_OPCODE_WIDTH = 6;

  // opcode[5:3]; opcode[2] picks the variant inside each group
  typedef enum logic [2:0] {
    G_ADD = 3'd0,
    G_SUB = 3'd1,
    G_SHL = 3'd2,
    G_SHR = 3'd3,
    G_GT  = 3'd4,
    G_EQ  = 3'd5,
    G_MD  = 3'd6,
    G_SYS = 3'd7
  } op_grp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [5:0] OP_FINISH = 6'h3F;

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle for DATA_WIDTH cycles.
// ALU_MC_EXT_RESULT_EN widens the multiply accumulator to 2*DATA_WIDTH and exposes hi_o.
module alu_mc_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  div_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] lo_o,
`ifdef ALU_MC_EXT_RESULT_EN
  output logic [DATA_WIDTH-1:0] hi_o,
`endif
  output logic                  last_o,
  output logic                  div0_o
);

  localparam int W  = DATA_WIDTH;
`ifdef ALU_MC_EXT_RESULT_EN
  localparam int AW = 2 * W;
`else
  localparam int AW = W;
`endif
  localparam int CW = $clog2(W);

  // acc: product accumulator or partial remainder; opb: shifted multiplicand or divisor;
  // sh: multiplier (consumed LSB first) or dividend/quotient (shifted MSB first)
  logic [AW-1:0] acc_q, acc_d, opb_q, opb_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d, div_q, div_d;
  logic [W:0]    trial, rdiff;

  assign last_o = run_q && (cnt_q == CW'(W - 1));
  assign div0_o = div_i && (b_i == '0);

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    run_d = run_q;
    div_d = div_q;
    trial = {acc_q[W-1:0], sh_q[W-1]};
    rdiff = trial - {1'b0, opb_q[W-1:0]};
    if (start_i) begin
      acc_d = '0;
      opb_d = AW'(b_i);
      sh_d  = a_i;
      cnt_d = '0;
      run_d = 1'b1;
      div_d = div_i;
    end else if (run_q) begin
      if (div_q) begin
        // borrow out of the trial subtraction means restore
        if (!rdiff[W]) begin
          acc_d = AW'(rdiff[W-1:0]);
          sh_d  = {sh_q[W-2:0], 1'b1};
        end else begin
          acc_d = AW'(trial[W-1:0]);
          sh_d  = {sh_q[W-2:0], 1'b0};
        end
      end else begin
        if (sh_q[0]) acc_d = acc_q + opb_q;
        opb_d = opb_q << 1;
        sh_d  = sh_q >> 1;
      end
      cnt_d = cnt_q + CW'(1);
      if (last_o) run_d = 1'b0;
    end
  end

  // Next-state view so the final step can be captured on the same edge it completes
  assign lo_o = div_q ? sh_d : acc_d[W-1:0];
`ifdef ALU_MC_EXT_RESULT_EN
  assign hi_o = div_q ? acc_d[W-1:0] : acc_d[AW-1:W];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      opb_q <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multicycle ALU: start/done handshake, single-cycle logic/arith ops, iterative MUL/DIV, err and sticky halt.
// ALU_MC_EXT_RESULT_EN enables result_hi (product high half / remainder); otherwise result_hi is 0.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
  parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   value1,
  input  logic [DATA_WIDTH-1:0]   value2,
  input  logic [BUS_WIDTH-1:0]    addr1,
  input  logic [BUS_WIDTH-1:0]    addr2,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result,
  output logic [DATA_WIDTH-1:0]   result_hi,
  output logic                    err,
  output logic                    halt
);

  localparam int DW = DATA_WIDTH;
  localparam logic [DW-1:0] SH_LIM = DW'(DATA_WIDTH);

  state_e        state_q, state_d;
  logic          done_q, done_d, err_q, err_d, halt_q, halt_d;
  logic [DW-1:0] result_q, result_d, hi_q, hi_d;
  logic [DW-1:0] a1x, a2x, op1, op2, alu_res, md_lo, md_hi;
  logic          accept, md_start, md_last, md_div0, var_b;
  op_grp_e       grp;

  // Address operands are zero-extended or truncated to the datapath width
  if (BUS_WIDTH >= DW) begin : g_addr_trunc
    assign a1x = addr1[DW-1:0];
    assign a2x = addr2[DW-1:0];
  end else begin : g_addr_ext
    assign a1x = {{(DW-BUS_WIDTH){1'b0}}, addr1};
    assign a2x = {{(DW-BUS_WIDTH){1'b0}}, addr2};
  end

  assign op1    = opcode[0] ? a1x : value1;
  assign op2    = opcode[1] ? a2x : value2;
  assign grp    = op_grp_e'(opcode[5:3]);
  assign var_b  = opcode[2];
  assign accept = start && (state_q == IDLE) && !halt_q;

  always_comb begin
    alu_res = '0;
    case (grp)
      G_ADD: alu_res = var_b ? (op1 ^ op2) : (op1 + op2);
      G_SUB: alu_res = var_b ? (op1 | op2) : (op1 - op2);
      G_SHL: alu_res = var_b ? ~(op1 | op2) : ((op2 >= SH_LIM) ? '0 : (op1 << op2));
      G_SHR: alu_res = var_b ? (op1 & op2) : ((op2 >= SH_LIM) ? '0 : (op1 >> op2));
      G_GT:  alu_res = var_b ? ~(op1 & op2) : {DW{op1 > op2}};
      G_EQ:  alu_res = var_b ? ~(op1 ^ op2) : {DW{op1 == op2}};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    err_d    = err_q;
    halt_d   = halt_q;
    result_d = result_q;
    hi_d     = hi_q;
    md_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d = 1'b0;
          hi_d  = '0;
          if (grp == G_MD) begin
            if (md_div0) begin
              done_d   = 1'b1;
              err_d    = 1'b1;
              result_d = '1;
            end else begin
              md_start = 1'b1;
              state_d  = CALC;
            end
          end else if (grp == G_SYS) begin
            // FINISH and the reserved codes leave result untouched
            done_d = 1'b1;
            if (opcode[5:0] == OP_FINISH) halt_d = 1'b1;
            else                          err_d  = 1'b1;
          end else begin
            done_d   = 1'b1;
            result_d = alu_res;
          end
        end
      end
      CALC: begin
        if (md_last) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = md_lo;
          hi_d     = md_hi;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  alu_mc_muldiv #(.DATA_WIDTH(DW)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .div_i   (var_b),
    .a_i     (op1),
    .b_i     (op2),
    .lo_o    (md_lo),
`ifdef ALU_MC_EXT_RESULT_EN
    .hi_o    (md_hi),
`endif
    .last_o  (md_last),
    .div0_o  (md_div0)
  );

`ifndef ALU_MC_EXT_RESULT_EN
  assign md_hi = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      halt_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      err_q    <= err_d;
      halt_q   <= halt_d;
      result_q <= result_d;
      hi_q     <= hi_d;
    end
  end

  assign busy      = (state_q == CALC);
  assign done      = done_q;
  assign err       = err_q;
  assign halt      = halt_q;
  assign result    = result_q;
  assign result_hi = hi_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (DATA_WIDTH=8): vector table through a scoreboard plus hand-written corner sequences.
module tb_alu_mc;

  typedef struct {
    logic [5:0] op;
    logic [7:0] v1, v2, a1, a2;
    logic [7:0] res, hi;
    logic       chk_hi;
    logic       err;
    logic       halt;
    int         lat;
    int         bsy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] value1, value2, addr1, addr2;
  logic [5:0] opcode;
  logic       busy, done, err, halt;
  logic [7:0] result, result_hi;

  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  vec_t sb[$];

  alu_mc #(.DATA_WIDTH(8), .BUS_WIDTH(8), .OPCODE_WIDTH(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .value1    (value1),
    .value2    (value2),
    .addr1     (addr1),
    .addr2     (addr2),
    .opcode    (opcode),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .err       (err),
    .halt      (halt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [7:0] v1, input logic [7:0] v2,
                              input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] res,
                              input logic [7:0] hi, input logic e, input int lat, input int bsy);
    vec_t r;
    r.op = op; r.v1 = v1; r.v2 = v2; r.a1 = a1; r.a2 = a2;
    r.res = res; r.hi = hi; r.chk_hi = 1'b1; r.err = e; r.halt = 1'b0;
    r.lat = lat; r.bsy = bsy;
    return r;
  endfunction

  function automatic logic [7:0] exp_hi(input logic [7:0] h);
`ifdef ALU_MC_EXT_RESULT_EN
    return h;
`else
    return 8'h00 & h;
`endif
  endfunction

  task automatic drive(input logic [5:0] op, input logic [7:0] v1, input logic [7:0] v2,
                       input logic [7:0] a1, input logic [7:0] a2);
    start = 1'b1; opcode = op; value1 = v1; value2 = v2; addr1 = a1; addr2 = a2;
  endtask

  // Launch one op, wait (bounded) for done, then pop the scoreboard and compare
  task automatic run_op(input vec_t v, input string tag);
    vec_t e;
    int   lat, bsy;
    @(negedge clk);
    drive(v.op, v.v1, v.v2, v.a1, v.a2);
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    lat = 1; bsy = 0;
    while (!done && lat < 40) begin
      if (busy) bsy++;
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: no done after %0d cycles, expected latency %0d", tag, lat, e.lat);
    end else begin
      chk({tag, " result"}, 32'(result), 32'(e.res));
      if (e.chk_hi) chk({tag, " result_hi"}, 32'(result_hi), 32'(exp_hi(e.hi)));
      chk({tag, " err"}, 32'(err), 32'(e.err));
      chk({tag, " halt"}, 32'(halt), 32'(e.halt));
      chk({tag, " latency"}, 32'(lat), 32'(e.lat));
      chk({tag, " busy cycles"}, 32'(bsy), 32'(e.bsy));
    end
  endtask

  initial begin
    vec_t v;
    int   lat, ndone;
    rst = 1'b1; start = 1'b0; opcode = '0;
    value1 = '0; value2 = '0; addr1 = '0; addr2 = '0;

    vecs.push_back(mk(6'h00, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h80, 8'h00, 1'b0, 1, 0)); // ADD
    vecs.push_back(mk(6'h04, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'hCC, 8'h00, 1'b0, 1, 0)); // XOR
    vecs.push_back(mk(6'h30, 8'd200, 8'd3, 8'h00, 8'h00, 8'h58, 8'h02, 1'b0, 9, 8)); // MUL
    vecs.push_back(mk(6'h34, 8'd100, 8'd7, 8'h00, 8'h00, 8'd14, 8'd2, 1'b0, 9, 8));  // DIV
    v = mk(6'h34, 8'd5, 8'd0, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1, 1, 0);               // DIV by 0
    v.chk_hi = 1'b0;
    vecs.push_back(v);
    vecs.push_back(mk(6'h10, 8'h01, 8'd9, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1, 0));  // SHL >= width
    vecs.push_back(mk(6'h10, 8'h01, 8'd3, 8'h00, 8'h00, 8'h08, 8'h00, 1'b0, 1, 0));
    vecs.push_back(mk(6'h18, 8'h80, 8'd7, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0, 1, 0));  // SHR
    vecs.push_back(mk(6'h18, 8'h80, 8'd8, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1, 0));
    vecs.push_back(mk(6'h20, 8'h80, 8'h7F, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1, 0)); // GT
    vecs.push_back(mk(6'h20, 8'h7F, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1, 0));
    vecs.push_back(mk(6'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1, 0)); // SUB wrap
    vecs.push_back(mk(6'h0C, 8'hF0, 8'h0F, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1, 0)); // OR
    vecs.push_back(mk(6'h14, 8'hF0, 8'h0C, 8'h00, 8'h00, 8'h03, 8'h00, 1'b0, 1, 0)); // NOR
    vecs.push_back(mk(6'h1C, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'h30, 8'h00, 1'b0, 1, 0)); // AND
    vecs.push_back(mk(6'h24, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'hCF, 8'h00, 1'b0, 1, 0)); // NAND
    vecs.push_back(mk(6'h28, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1, 0)); // EQ
    vecs.push_back(mk(6'h28, 8'h5A, 8'h5B, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1, 0));
    vecs.push_back(mk(6'h2C, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'h33, 8'h00, 1'b0, 1, 0)); // XNOR
    vecs.push_back(mk(6'h03, 8'h10, 8'h20, 8'd3, 8'd4, 8'd7, 8'h00, 1'b0, 1, 0));    // both from addr
    vecs.push_back(mk(6'h01, 8'h10, 8'h20, 8'd3, 8'd4, 8'h23, 8'h00, 1'b0, 1, 0));   // op1 from addr
    vecs.push_back(mk(6'h30, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'hFE, 1'b0, 9, 8)); // MUL max
    vecs.push_back(mk(6'h34, 8'hFF, 8'h10, 8'h00, 8'h00, 8'h0F, 8'h0F, 1'b0, 9, 8)); // DIV
    vecs.push_back(mk(6'h00, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1, 0)); // ADD wrap

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset result", 32'(result), 0);
    chk("reset result_hi", 32'(result_hi), 0);
    chk("reset err", 32'(err), 0);
    chk("reset halt", 32'(halt), 0);

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Start pulses while a MUL is iterating must be ignored
    @(negedge clk);
    drive(6'h30, 8'd200, 8'd3, 8'h00, 8'h00);
    @(negedge clk);
    drive(6'h00, 8'h11, 8'h22, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    start = 1'b0;
    chk("mul busy mid", 32'(busy), 1);
    lat = 5;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("mul ignore latency", 32'(lat), 9);
    chk("mul ignore result", 32'(result), 32'h58);
    chk("mul ignore result_hi", 32'(result_hi), 32'(exp_hi(8'h02)));
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no extra done", 32'(ndone), 0);

    // Reset in the 4th CALC cycle discards the op
    drive(6'h30, 8'd200, 8'd3, 8'h00, 8'h00);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("calc4 busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midop rst busy", 32'(busy), 0);
    chk("midop rst done", 32'(done), 0);
    chk("midop rst result", 32'(result), 0);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midop rst no done", 32'(ndone), 0);

    // Reserved opcode keeps result and flags err until the next accepted op
    run_op(mk(6'h00, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h80, 8'h00, 1'b0, 1, 0), "pre-rsvd");
    run_op(mk(6'h3E, 8'h12, 8'h34, 8'h00, 8'h00, 8'h80, 8'h00, 1'b1, 1, 0), "rsvd");
    run_op(mk(6'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 1'b0, 1, 0), "post-rsvd");

    // FINISH halts; later starts produce no done until reset
    v = mk(6'h3F, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h02, 8'h00, 1'b0, 1, 0);
    v.halt = 1'b1;
    run_op(v, "finish");
    @(negedge clk);
    drive(6'h00, 8'h01, 8'h02, 8'h00, 8'h00);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
    end
    chk("halted no done", 32'(ndone), 0);
    chk("halted halt", 32'(halt), 1);
    chk("halted result", 32'(result), 32'h02);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst clears halt", 32'(halt), 0);
    run_op(mk(6'h00, 8'h03, 8'h04, 8'h00, 8'h00, 8'h07, 8'h00, 1'b0, 1, 0), "after-halt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
